load_store_unit: RTL

Data-memory stage of the multi-cycle CPU. It serves the controller's MEM state for sw/sh/sb and lw/lh/lhu/lb/lbu. The block owns the word-organised data array and runs a small FSM with a req/done handshake. Sub-word stores are done as read-modify-write. Loads return lane-extracted and sign- or zero-extended data.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_byte_lane.sv | 42 ++++
 rtl/load_store_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states and the
// alignment rule.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // Reserved size 2'b11 is checked like a word access.
    function automatic logic lsu_misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic w_mis;
        case (sz)
            SZ_BYTE: w_mis = 1'b0;
            SZ_HALF: w_mis = off[0];
            default: w_mis = (off != 2'b00);
        endcase
        return w_mis;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts and extends load data from a word, and
// merges right-aligned store data into the addressed lane of a word.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_sign_ext,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_off, 3'b000} +: 8];
    assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_load   = i_word;
        o_merged = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_load   = {{24{i_sign_ext & w_byte[7]}}, w_byte};
                o_merged = i_word;
                o_merged[{i_off, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_load   = {{16{i_sign_ext & w_half[15]}}, w_half};
                o_merged = i_word;
                o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: begin
                o_load   = i_word;
                o_merged = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: word-organised array behind a req/done FSM, with
// read-modify-write for sub-word stores and lane-extended loads.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              misalign,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0] dataMem [DEPTH_WORDS];

    lsu_state_t     r_state;
    logic           r_we;
    logic [1:0]     r_size;
    logic           r_sign_ext;
    logic [IDX_W+1:0] r_addr;
    logic [31:0]    r_wdata;
    logic           r_mis;
    logic [31:0]    r_hold;
    logic [31:0]    r_rdata;
    logic           r_done;
    logic           r_misalign;
    logic           r_busy;

    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_load;
    logic [31:0]      w_merged;
    logic             w_unused_addr;

    // Upper address bits are deliberately dropped so accesses wrap.
    assign w_unused_addr = ^addr[ADDR_W-1:IDX_W+2];
    assign w_idx         = r_addr[IDX_W+1:2];

    lsu_byte_lane u_lane (
        .i_word     (r_hold),
        .i_off      (r_addr[1:0]),
        .i_size     (r_size),
        .i_sign_ext (r_sign_ext),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_merged   (w_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_sign_ext <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mis      <= 1'b0;
            r_hold     <= '0;
            r_rdata    <= '0;
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_we       <= we;
                        r_size     <= size;
                        r_sign_ext <= sign_ext;
                        r_addr     <= addr[IDX_W+1:0];
                        r_wdata    <= wdata;
                        r_mis      <= lsu_misaligned(size, addr[1:0]);
                        r_busy     <= 1'b1;
                        r_state    <= lsu_misaligned(size, addr[1:0]) ? RESP : READ;
                    end
                end
                READ: begin
                    r_hold  <= dataMem[w_idx];
                    r_state <= r_we ? WRITE : RESP;
                end
                WRITE: begin
                    r_state <= RESP;
                end
                RESP: begin
                    r_done     <= 1'b1;
                    r_misalign <= r_mis;
                    if (r_mis)
                        r_rdata <= '0;
                    else if (!r_we)
                        r_rdata <= w_load;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // No reset on the array; async reset drops r_state out of WRITE so an
    // aborted store cannot commit.
    always_ff @(posedge clk) begin
        if (r_state == WRITE)
            dataMem[w_idx] <= w_merged;
    end

    assign rdata    = r_rdata;
    assign done     = r_done;
    assign misalign = r_misalign;
    assign busy     = r_busy;

endmodule
